slow_packet_reader: RTL

//  Reads the 16-word "ABPM" event packets from the slow FIFO, one packet at a time. Checks the PID, resynchronises on framing loss,

---
 rtl/slow_packet_reader_pkg.sv | 22 ++
 rtl/slow_packet_reader_sat.sv | 21 ++
 rtl/slow_packet_reader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/slow_packet_reader_pkg.sv
// Shared constants and FSM encoding for the slow FIFO packet reader.
package slow_packet_reader_pkg;

    localparam int          DEF_PACKET_LEN = 16;
    localparam logic [31:0] DEF_PID        = 32'h4142504d;

    localparam int W_PID  = 0;
    localparam int W_STAT = 1;
    localparam int W_XY   = 2;
    localparam int W_S    = 3;
    localparam int W_ZERO = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_HUNT,
        S_HUNT_CMP,
        S_RESUME
    } state_t;

endpackage

// File: rtl/slow_packet_reader_sat.sv
// 16-bit counter that adds inc when enabled and sticks at 0xFFFF.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] inc,
    output logic [15:0] cnt
);

    logic [16:0] sum;

    assign sum = {1'b0, cnt} + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en)
            cnt <= sum[16] ? 16'hFFFF : sum[15:0];
    end

endmodule

// File: rtl/slow_packet_reader.sv
// Reads ABPM packets from the slow FIFO, resyncs on lost framing and holds
// the last good packet plus error statistics for the MB register map.
module slow_packet_reader
    import slow_packet_reader_pkg::*;
#(
    parameter int          SFIFO_WIDTH = 32,
    parameter int          PACKET_LEN  = DEF_PACKET_LEN,
    parameter int          CNT_WIDTH   = 6,
    parameter logic [31:0] PID         = DEF_PID
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CNT_WIDTH-1:0]       slow_fifo_wd,
    input  logic [SFIFO_WIDTH-1:0]     slow_fifo_dout,
    output logic                       sFIFO_rd,
    input  logic                       pkt_ack,
    output logic                       pkt_rdy,
    output logic [PACKET_LEN*32-1:0]   pkt_words,
    output logic [15:0]                evt_cnt,
    output logic [15:0]                status,
    output logic [15:0]                x_pos,
    output logic [15:0]                y_pos,
    output logic [15:0]                s_pos,
    output logic [15:0]                pkt_cnt,
    output logic [15:0]                sync_err_cnt,
    output logic [15:0]                fmt_err_cnt,
    output logic [15:0]                evt_gap_cnt
);

    localparam int IDX_W = $clog2(PACKET_LEN);
    localparam int RC_W  = IDX_W + 1;

    state_t                 state, next_state;
    logic [31:0]            shadow [PACKET_LEN];
    logic [RC_W-1:0]        rd_cnt;
    logic [IDX_W-1:0]       cap_idx;
    logic                   cap_vld;
    logic                   start_new, start_resume;
    logic                   commit, sync_inc, fmt_inc, good;
    logic                   have_prev;
    logic [15:0]            evt_prev, evt_new, gap;
    logic [PACKET_LEN*32-1:0] held;

    assign good    = (shadow[W_PID] == PID) && (shadow[W_S][15:0] == 16'h0) &&
                     (shadow[W_ZERO] == 32'h0);
    assign evt_new = shadow[W_STAT][15:0];
    assign gap     = evt_new - evt_prev - 16'd1;

    always_comb begin
        next_state   = state;
        sFIFO_rd     = 1'b0;
        start_new    = 1'b0;
        start_resume = 1'b0;
        commit       = 1'b0;
        sync_inc     = 1'b0;
        fmt_inc      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!pkt_rdy && slow_fifo_wd >= CNT_WIDTH'(PACKET_LEN)) begin
                    sFIFO_rd   = 1'b1;
                    start_new  = 1'b1;
                    next_state = S_READ;
                end
            end
            S_READ: begin
                sFIFO_rd = (rd_cnt != RC_W'(PACKET_LEN));
                if (cap_vld && cap_idx == IDX_W'(PACKET_LEN - 1))
                    next_state = S_CHECK;
            end
            S_CHECK: begin
                if (good) begin
                    commit     = 1'b1;
                    next_state = S_IDLE;
                end else if (shadow[W_PID] != PID) begin
                    sync_inc   = 1'b1;
                    next_state = S_HUNT;
                end else begin
                    fmt_inc    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_HUNT: begin
                if (slow_fifo_wd != '0) begin
                    sFIFO_rd   = 1'b1;
                    next_state = S_HUNT_CMP;
                end
            end
            S_HUNT_CMP: begin
                if (slow_fifo_dout[31:0] == PID)
                    next_state = S_RESUME;
                else begin
                    sync_inc   = 1'b1;
                    next_state = S_HUNT;
                end
            end
            S_RESUME: begin
                // PID already sits in word 0; fetch the rest in one burst
                if (slow_fifo_wd >= CNT_WIDTH'(PACKET_LEN - 1)) begin
                    sFIFO_rd     = 1'b1;
                    start_resume = 1'b1;
                    next_state   = S_READ;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rd_cnt  <= '0;
            cap_idx <= '0;
            cap_vld <= 1'b0;
        end else begin
            state   <= next_state;
            cap_vld <= sFIFO_rd && (state != S_HUNT);
            if (cap_vld)
                cap_idx <= cap_idx + 1'b1;
            if (state == S_READ && sFIFO_rd)
                rd_cnt <= rd_cnt + 1'b1;
            if (start_new) begin
                rd_cnt  <= RC_W'(1);
                cap_idx <= '0;
            end
            if (start_resume) begin
                rd_cnt  <= RC_W'(2);
                cap_idx <= IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_vld)
            shadow[cap_idx] <= slow_fifo_dout[31:0];
        else if (state == S_HUNT_CMP)
            shadow[W_PID] <= slow_fifo_dout[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held      <= '0;
            pkt_rdy   <= 1'b0;
            pkt_cnt   <= '0;
            evt_prev  <= '0;
            have_prev <= 1'b0;
        end else if (commit) begin
            for (int i = 0; i < PACKET_LEN; i++)
                held[32*i +: 32] <= shadow[i];
            pkt_rdy   <= 1'b1;
            pkt_cnt   <= pkt_cnt + 16'd1;
            evt_prev  <= evt_new;
            have_prev <= 1'b1;
        end else if (pkt_ack && pkt_rdy) begin
            pkt_rdy <= 1'b0;
        end
    end

    sat_counter16 u_sync_err (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sync_inc),
        .inc   (16'd1),
        .cnt   (sync_err_cnt)
    );

    sat_counter16 u_fmt_err (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fmt_inc),
        .inc   (16'd1),
        .cnt   (fmt_err_cnt)
    );

    sat_counter16 u_evt_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (commit && have_prev && (gap != 16'h0)),
        .inc   (gap),
        .cnt   (evt_gap_cnt)
    );

    assign pkt_words = held;
    assign evt_cnt   = held[32*W_STAT      +: 16];
    assign status    = held[32*W_STAT + 16 +: 16];
    assign x_pos     = held[32*W_XY + 16   +: 16];
    assign y_pos     = held[32*W_XY        +: 16];
    assign s_pos     = held[32*W_S + 16    +: 16];

endmodule
